mips_mc_ctrl: RTL and testbench
===============================

# mips_mc_ctrl

Multicycle MIPS control unit: a Moore/Mealy FSM that sequences a shared-memory datapath through fetch, decode, execute, memory and writeback steps, one step per clock. It replaces the single-cycle decoder-plus-datapath arrangement with a state machine. Memory accesses use a request/ready handshake so that wait states are possible, and the ADDI and J instruction groups are enabled by parameters. It sits between the instruction register/ALU flags of the multicycle datapath and that datapath's enables and muxes.

## Interface
- `SUPPORT_ADDI`, default 1: when 1, decode opcode 001000; when 0, treat it as illegal.
- `SUPPORT_J`, default 1: when 1, decode opcode 000010; when 0, treat it as illegal.
- `clk` in 1: rising-edge clock. Single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `opcode` in 6: `instr[31:26]` from the instruction register.
- `funct` in 6: `instr[5:0]`.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `mem_req` out 1: memory access requested.
- `mem_write` out 1: the access is a write.
- `iord` out 1: 0 selects PC as the memory address; 1 selects ALUOut.
- `ir_write` out 1: load the instruction register.
- `pc_en` out 1: PC write enable, equal to `pc_write | (branch & zero)`.
- `reg_write` out 1: register file write enable.
- `reg_dst` out 1: 1 selects rd; 0 selects rt.
- `mem_to_reg` out 1: 1 selects the data register; 0 selects ALUOut.
- `alu_src_a` out 1: 0 selects PC; 1 selects register A.
- `alu_src_b` out 2: 00 selects B; 01 selects the constant 4; 10 selects sign-extended imm; 11 selects sign-extended imm << 2.
- `pc_src` out 2: 00 selects the ALU result; 01 selects ALUOut; 10 selects the jump target.
- `alu_ctrl` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal` out 1: one-cycle pulse when an undecodable instruction is detected.
- `state_out` out 4: current state, for debug.

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unused and always return to FETCH.
- FETCH: `mem_req=1`, `iord=0`, `alu_src_a=0`, `alu_src_b=01`, `alu_ctrl=add`, `pc_src=00`. `ir_write` and `pc_write` equal `mem_ready`. Stay in FETCH while `!mem_ready`; go to DECODE on `mem_ready`.
- DECODE: `alu_src_b=11`, add (branch target into ALUOut). Next state by opcode:
  - lw or sw → MEMADR
  - R-type → EXEC
  - beq → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - any other opcode, or a disabled one → FETCH, with `illegal=1` for that cycle.
- MEMADR: `alu_src_a=1`, `alu_src_b=10`, add. lw → MEMRD; sw → MEMWR.
- MEMRD: `mem_req=1`, `iord=1`. Hold until `mem_ready`, then go to MEMWB.
- MEMWR: `mem_req=1`, `mem_write=1`, `iord=1`. Hold until `mem_ready`, then go to FETCH.
- MEMWB: `reg_write=1`, `reg_dst=0`, `mem_to_reg=1` → FETCH.
- EXEC: `alu_src_a=1`, `alu_src_b=00`, and `alu_ctrl` decoded from `funct`: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. An unknown `funct` raises `illegal` and goes to FETCH; otherwise go to ALUWB.
- ALUWB: `reg_write=1`, `reg_dst=1`, `mem_to_reg=0` → FETCH.
- BRANCH: `alu_src_a=1`, `alu_src_b=00`, sub, `branch=1`, `pc_src=01` → FETCH.
- ADDIEX: `alu_src_a=1`, `alu_src_b=10`, add → ADDIWB.
- ADDIWB: `reg_write=1`, `reg_dst=0`, `mem_to_reg=0` → FETCH.
- JUMP: `pc_src=10`, `pc_write=1` → FETCH.
- Any output not listed for a state is 0.
- The `mem_req` handshake:
  - `mem_req` and the address select stay stable until `mem_ready`.
  - `mem_ready` while `mem_req=0` is ignored.
  - `mem_write` is asserted only together with `mem_req`.

## Timing
- `state` is registered. Outputs are combinational from `state`, plus `mem_ready`, `zero` and `funct` where listed above.
- Reset: `state` is FETCH on the cycle after `rst` is sampled high. `rst` takes priority over every transition, including mid-access: an outstanding request is abandoned and no write enable is asserted while `rst=1`.
- Outputs during and after reset equal the FETCH values with `mem_ready=0`:
  - `mem_req=1`, `alu_src_b=01`, `alu_ctrl=010`
  - all other outputs 0, `state_out=0`.
- Cycles per instruction with zero wait states:
  - lw 5
  - sw, R-type and addi 4
  - beq and j 3
  - illegal 2.
- Each wait state (`mem_ready=0` in FETCH, MEMRD or MEMWR) adds exactly one cycle and causes no side effects.

## Structure
- Package `mips_mc_pkg` holds:
  - the state enum (4-bit)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALU control codes
  - `alu_src_b` and `pc_src` select codes.
- Sub-module `mips_mc_alu_dec`: combinational mapping from ALU op class and `funct` to `alu_ctrl` plus a `funct_illegal` flag.
- The FSM next-state logic and output decode live in `mips_mc_ctrl`.

## Test plan
- Reset, then `lw` (opcode 100011) with `mem_ready` held at 1:
  - states 0→1→2→3→4→0
  - `reg_write` high only in state 4, with `mem_to_reg=1`.
- `sw` with `mem_ready` held low for 3 cycles in MEMWR:
  - `mem_req`, `mem_write` and `iord` held for 4 cycles, then FETCH
  - `reg_write` never asserted.
- R-type `funct`=101010:
  - EXEC shows `alu_ctrl=111`, ALUWB shows `reg_dst=1`.
  - `funct`=000111 instead: `illegal` pulses in EXEC and the next state is FETCH.
- `beq`:
  - `zero=1` in BRANCH gives `pc_en=1`, `pc_src=01`
  - `zero=0` gives `pc_en=0`; both go to FETCH.
- `SUPPORT_J=0` with opcode 000010: `illegal` pulses in DECODE and the next state is 0. `SUPPORT_J=1`: JUMP gives `pc_en=1`, `pc_src=10`.
- `rst` asserted during a MEMRD wait:
  - next state is FETCH
  - no `reg_write`, `mem_write`, `ir_write` or `pc_en` seen afterwards until a new fetch completes.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// ============================================================================
// mips_mc_pkg : shared constants for the multicycle MIPS control unit
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_mc_pkg;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_ALUWB  = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_ADDIEX = 4'd9;
  localparam logic [3:0] ST_ADDIWB = 4'd10;
  localparam logic [3:0] ST_JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [2:0] ALU_IDLE = 3'b000;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_NONE  = 2'd0,
    ALUOP_ADD   = 2'd1,
    ALUOP_SUB   = 2'd2,
    ALUOP_FUNCT = 2'd3
  } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/mips_mc_alu_dec.sv
// ============================================================================
// mips_mc_alu_dec : ALU op class + funct -> alu_ctrl, flags unknown funct
// Rev 1.0
// ============================================================================
`default_nettype none

module mips_mc_alu_dec
  import mips_mc_pkg::*;
(
  input  alu_op_e     alu_op,
  input  logic [5:0]  funct,
  output logic [2:0]  alu_ctrl,
  output logic        funct_illegal
);

  always_comb begin
    alu_ctrl      = ALU_IDLE;
    funct_illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alu_ctrl = ALU_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
// ============================================================================
// mips_mc_ctrl : multicycle MIPS control FSM with mem_req/mem_ready handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int SUPPORT_ADDI = 1,
  parameter int SUPPORT_J    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_en,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_ctrl,
  output logic        illegal,
  output logic [3:0]  state_out
);

  localparam bit ADDI_EN = (SUPPORT_ADDI != 0);
  localparam bit J_EN    = (SUPPORT_J != 0);

  logic [3:0] state_q, state_d;
  logic [3:0] cur_state;
  logic       ready;
  logic       pc_write;
  logic       branch;
  logic       funct_illegal;
  alu_op_e    alu_op;

  // While rst is high the outputs behave as an idle FETCH, so an in-flight
  // access is dropped and no enable can fire before the state register clears.
  assign cur_state = rst ? ST_FETCH : state_q;
  assign ready     = mem_ready & ~rst;

  mips_mc_alu_dec u_alu_dec (
    .alu_op        (alu_op),
    .funct         (funct),
    .alu_ctrl      (alu_ctrl),
    .funct_illegal (funct_illegal)
  );

  always_comb begin
    state_d    = ST_FETCH;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PCSRC_ALU;
    alu_op     = ALUOP_NONE;
    illegal    = 1'b0;
    case (cur_state)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALUOP_ADD;
        ir_write  = ready;
        pc_write  = ready;
        state_d   = ready ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        alu_op    = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI: begin
            if (ADDI_EN) state_d = ST_ADDIEX;
            else         illegal = 1'b1;
          end
          OP_J: begin
            if (J_EN) state_d = ST_JUMP;
            else      illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        state_d   = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        state_d = ready ? ST_MEMWB : ST_MEMRD;
      end
      ST_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = ready ? ST_FETCH : ST_MEMWR;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        illegal   = funct_illegal;
        state_d   = funct_illegal ? ST_FETCH : ST_ALUWB;
      end
      ST_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        pc_src    = PCSRC_ALUOUT;
      end
      ST_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        state_d   = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        reg_write = 1'b1;
      end
      ST_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign pc_en     = pc_write | (branch & zero);
  assign state_out = cur_state;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
// ============================================================================
// tb_mips_mc_ctrl : directed self-checking bench for mips_mc_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       mem_req, mem_write, iord, ir_write, pc_en, reg_write, reg_dst;
  logic       mem_to_reg, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state_out;

  logic       nj_mem_req, nj_mem_write, nj_iord, nj_ir_write, nj_pc_en, nj_reg_write;
  logic       nj_reg_dst, nj_mem_to_reg, nj_alu_src_a, nj_illegal;
  logic [1:0] nj_alu_src_b, nj_pc_src;
  logic [2:0] nj_alu_ctrl;
  logic [3:0] nj_state_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.SUPPORT_ADDI(1), .SUPPORT_J(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_en(pc_en), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .alu_ctrl(alu_ctrl), .illegal(illegal), .state_out(state_out)
  );

  mips_mc_ctrl #(.SUPPORT_ADDI(1), .SUPPORT_J(0)) dut_nj (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(nj_mem_req), .mem_write(nj_mem_write),
    .iord(nj_iord), .ir_write(nj_ir_write), .pc_en(nj_pc_en),
    .reg_write(nj_reg_write), .reg_dst(nj_reg_dst), .mem_to_reg(nj_mem_to_reg),
    .alu_src_a(nj_alu_src_a), .alu_src_b(nj_alu_src_b), .pc_src(nj_pc_src),
    .alu_ctrl(nj_alu_ctrl), .illegal(nj_illegal), .state_out(nj_state_out)
  );

  // Packed view: {mem_req, mem_write, iord, ir_write, pc_en, reg_write, reg_dst,
  // mem_to_reg, alu_src_a, illegal, alu_src_b, pc_src, alu_ctrl, state_out}
  logic [20:0] obs, obs_nj;
  assign obs = {mem_req, mem_write, iord, ir_write, pc_en, reg_write, reg_dst,
                mem_to_reg, alu_src_a, illegal, alu_src_b, pc_src, alu_ctrl, state_out};
  assign obs_nj = {nj_mem_req, nj_mem_write, nj_iord, nj_ir_write, nj_pc_en,
                   nj_reg_write, nj_reg_dst, nj_mem_to_reg, nj_alu_src_a, nj_illegal,
                   nj_alu_src_b, nj_pc_src, nj_alu_ctrl, nj_state_out};

  localparam logic [20:0] V_FETCH_RDY  = {10'b1001100000, 2'b01, 2'b00, 3'b010, 4'd0};
  localparam logic [20:0] V_FETCH_IDLE = {10'b1000000000, 2'b01, 2'b00, 3'b010, 4'd0};
  localparam logic [20:0] V_DECODE     = {10'b0000000000, 2'b11, 2'b00, 3'b010, 4'd1};
  localparam logic [20:0] V_DEC_ILL    = {10'b0000000001, 2'b11, 2'b00, 3'b010, 4'd1};
  localparam logic [20:0] V_MEMADR     = {10'b0000000010, 2'b10, 2'b00, 3'b010, 4'd2};
  localparam logic [20:0] V_MEMRD      = {10'b1010000000, 2'b00, 2'b00, 3'b000, 4'd3};
  localparam logic [20:0] V_MEMWB      = {10'b0000010100, 2'b00, 2'b00, 3'b000, 4'd4};
  localparam logic [20:0] V_MEMWR      = {10'b1110000000, 2'b00, 2'b00, 3'b000, 4'd5};
  localparam logic [20:0] V_EXEC_SLT   = {10'b0000000010, 2'b00, 2'b00, 3'b111, 4'd6};
  localparam logic [20:0] V_ALUWB      = {10'b0000011000, 2'b00, 2'b00, 3'b000, 4'd7};
  localparam logic [20:0] V_BR_Z1      = {10'b0000100010, 2'b00, 2'b01, 3'b110, 4'd8};
  localparam logic [20:0] V_BR_Z0      = {10'b0000000010, 2'b00, 2'b01, 3'b110, 4'd8};
  localparam logic [20:0] V_ADDIEX     = {10'b0000000010, 2'b10, 2'b00, 3'b010, 4'd9};
  localparam logic [20:0] V_ADDIWB     = {10'b0000010000, 2'b00, 2'b00, 3'b000, 4'd10};
  localparam logic [20:0] V_JUMP       = {10'b0000100000, 2'b00, 2'b10, 3'b000, 4'd11};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b0; opcode = 6'b0; funct = 6'b0; zero = 1'b0;
    tick(); tick();
    n_checks++; if (obs !== V_FETCH_IDLE) begin n_errors++; $display("FAIL reset_state: got %b want %b", obs, V_FETCH_IDLE); end
    n_checks++; if (obs_nj !== V_FETCH_IDLE) begin n_errors++; $display("FAIL reset_state_nj: got %b want %b", obs_nj, V_FETCH_IDLE); end
    mem_ready = 1'b1; #1;
    n_checks++; if (obs !== V_FETCH_IDLE) begin n_errors++; $display("FAIL reset_masks_ready: got %b want %b", obs, V_FETCH_IDLE); end
    rst = 1'b0; mem_ready = 1'b0; #1;
    n_checks++; if (obs !== V_FETCH_IDLE) begin n_errors++; $display("FAIL post_reset_idle: got %b want %b", obs, V_FETCH_IDLE); end
  endtask

  task automatic test_lw();
    opcode = 6'b100011; mem_ready = 1'b1; #1;
    n_checks++; if (obs !== V_FETCH_RDY) begin n_errors++; $display("FAIL lw_fetch: got %b want %b", obs, V_FETCH_RDY); end
    tick();
    n_checks++; if (obs !== V_DECODE) begin n_errors++; $display("FAIL lw_decode: got %b want %b", obs, V_DECODE); end
    tick();
    n_checks++; if (obs !== V_MEMADR) begin n_errors++; $display("FAIL lw_memadr: got %b want %b", obs, V_MEMADR); end
    tick();
    n_checks++; if (obs !== V_MEMRD) begin n_errors++; $display("FAIL lw_memrd: got %b want %b", obs, V_MEMRD); end
    tick();
    n_checks++; if (obs !== V_MEMWB) begin n_errors++; $display("FAIL lw_memwb: got %b want %b", obs, V_MEMWB); end
    tick();
    n_checks++; if (obs !== V_FETCH_RDY) begin n_errors++; $display("FAIL lw_back_to_fetch: got %b want %b", obs, V_FETCH_RDY); end
  endtask

  task automatic test_sw_wait();
    opcode = 6'b101011; mem_ready = 1'b1;
    tick();
    n_checks++; if (obs !== V_DECODE) begin n_errors++; $display("FAIL sw_decode: got %b want %b", obs, V_DECODE); end
    tick();
    n_checks++; if (obs !== V_MEMADR) begin n_errors++; $display("FAIL sw_memadr: got %b want %b", obs, V_MEMADR); end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (obs !== V_MEMWR) begin n_errors++; $display("FAIL sw_memwr_wait%0d: got %b want %b", i, obs, V_MEMWR); end
    end
    mem_ready = 1'b1; #1;
    n_checks++; if (obs !== V_MEMWR) begin n_errors++; $display("FAIL sw_memwr_done: got %b want %b", obs, V_MEMWR); end
    tick();
    mem_ready = 1'b0; #1;
    n_checks++; if (obs !== V_FETCH_IDLE) begin n_errors++; $display("FAIL sw_to_fetch: got %b want %b", obs, V_FETCH_IDLE); end
    tick();
    n_checks++; if (obs !== V_FETCH_IDLE) begin n_errors++; $display("FAIL fetch_wait_holds: got %b want %b", obs, V_FETCH_IDLE); end
  endtask

  task automatic test_rtype();
    opcode = 6'b000000; funct = 6'b101010; mem_ready = 1'b1;
    tick();
    n_checks++; if (obs !== V_DECODE) begin n_errors++; $display("FAIL rtype_decode: got %b want %b", obs, V_DECODE); end
    tick();
    n_checks++; if (obs !== V_EXEC_SLT) begin n_errors++; $display("FAIL rtype_exec_slt: got %b want %b", obs, V_EXEC_SLT); end
    tick();
    n_checks++; if (obs !== V_ALUWB) begin n_errors++; $display("FAIL rtype_aluwb: got %b want %b", obs, V_ALUWB); end
    tick();
    n_checks++; if (obs !== V_FETCH_RDY) begin n_errors++; $display("FAIL rtype_fetch: got %b want %b", obs, V_FETCH_RDY); end
    funct = 6'b000111;
    tick(); tick();
    n_checks++; if ({illegal, state_out} !== 5'b1_0110) begin n_errors++; $display("FAIL bad_funct_exec: got illegal=%b state=%0d want illegal=1 state=6", illegal, state_out); end
    tick();
    n_checks++; if (obs !== V_FETCH_RDY) begin n_errors++; $display("FAIL bad_funct_next: got %b want %b", obs, V_FETCH_RDY); end
  endtask

  task automatic test_beq();
    opcode = 6'b000100; zero = 1'b1; mem_ready = 1'b1;
    tick(); tick();
    n_checks++; if (obs !== V_BR_Z1) begin n_errors++; $display("FAIL beq_taken: got %b want %b", obs, V_BR_Z1); end
    zero = 1'b0; #1;
    n_checks++; if (obs !== V_BR_Z0) begin n_errors++; $display("FAIL beq_zero_drop: got %b want %b", obs, V_BR_Z0); end
    tick();
    n_checks++; if (obs !== V_FETCH_RDY) begin n_errors++; $display("FAIL beq_taken_fetch: got %b want %b", obs, V_FETCH_RDY); end
    tick(); tick();
    n_checks++; if (obs !== V_BR_Z0) begin n_errors++; $display("FAIL beq_not_taken: got %b want %b", obs, V_BR_Z0); end
    tick();
    n_checks++; if (obs !== V_FETCH_RDY) begin n_errors++; $display("FAIL beq_nt_fetch: got %b want %b", obs, V_FETCH_RDY); end
  endtask

  task automatic test_addi();
    opcode = 6'b001000; mem_ready = 1'b1;
    tick(); tick();
    n_checks++; if (obs !== V_ADDIEX) begin n_errors++; $display("FAIL addi_ex: got %b want %b", obs, V_ADDIEX); end
    tick();
    n_checks++; if (obs !== V_ADDIWB) begin n_errors++; $display("FAIL addi_wb: got %b want %b", obs, V_ADDIWB); end
    tick();
    n_checks++; if (obs !== V_FETCH_RDY) begin n_errors++; $display("FAIL addi_fetch: got %b want %b", obs, V_FETCH_RDY); end
  endtask

  task automatic test_jump();
    opcode = 6'b000010; mem_ready = 1'b1;
    tick();
    n_checks++; if (obs !== V_DECODE) begin n_errors++; $display("FAIL j_decode: got %b want %b", obs, V_DECODE); end
    n_checks++; if (obs_nj !== V_DEC_ILL) begin n_errors++; $display("FAIL j_disabled_decode: got %b want %b", obs_nj, V_DEC_ILL); end
    tick();
    n_checks++; if (obs !== V_JUMP) begin n_errors++; $display("FAIL j_jump: got %b want %b", obs, V_JUMP); end
    n_checks++; if (obs_nj !== V_FETCH_RDY) begin n_errors++; $display("FAIL j_disabled_next: got %b want %b", obs_nj, V_FETCH_RDY); end
    tick();
    n_checks++; if (obs !== V_FETCH_RDY) begin n_errors++; $display("FAIL j_fetch: got %b want %b", obs, V_FETCH_RDY); end
    rst = 1'b1; tick(); rst = 1'b0; #1;
  endtask

  task automatic test_reset_midaccess();
    opcode = 6'b100011; mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    n_checks++; if (obs !== V_MEMRD) begin n_errors++; $display("FAIL rst_mid_memrd: got %b want %b", obs, V_MEMRD); end
    tick();
    n_checks++; if (obs !== V_MEMRD) begin n_errors++; $display("FAIL rst_mid_memrd_hold: got %b want %b", obs, V_MEMRD); end
    rst = 1'b1; mem_ready = 1'b1; #1;
    n_checks++; if (obs !== V_FETCH_IDLE) begin n_errors++; $display("FAIL rst_mid_during: got %b want %b", obs, V_FETCH_IDLE); end
    tick();
    n_checks++; if (obs !== V_FETCH_IDLE) begin n_errors++; $display("FAIL rst_mid_after_edge: got %b want %b", obs, V_FETCH_IDLE); end
    rst = 1'b0; mem_ready = 1'b0; #1;
    n_checks++; if (obs !== V_FETCH_IDLE) begin n_errors++; $display("FAIL rst_mid_released: got %b want %b", obs, V_FETCH_IDLE); end
    tick();
    n_checks++; if (obs !== V_FETCH_IDLE) begin n_errors++; $display("FAIL rst_mid_no_enables: got %b want %b", obs, V_FETCH_IDLE); end
    mem_ready = 1'b1; #1;
    n_checks++; if (obs !== V_FETCH_RDY) begin n_errors++; $display("FAIL rst_mid_new_fetch: got %b want %b", obs, V_FETCH_RDY); end
    tick();
    n_checks++; if (obs !== V_DECODE) begin n_errors++; $display("FAIL rst_mid_decode: got %b want %b", obs, V_DECODE); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype();
    test_beq();
    test_addi();
    test_jump();
    test_reset_midaccess();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
